// File: rtl/mux4_arbiter.sv
// mux4_arbiter: four-requester round-robin arbiter driving a 4:1 data mux.
// A grant is held until the owner drops its request. The release edge always
// produces one IDLE cycle before the next grant.
// Optional feature: define ARB_TIMEOUT_EN to compile in a hold counter. This
// counter forces a release after TIMEOUT cycles of ownership, but only while
// another requester is waiting.
module mux4_arbiter #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    output logic [3:0]        gnt,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] out,
    output logic              busy
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t     state, state_next;
    logic [1:0] last, last_next;
    logic [1:0] sel_next;
    logic [3:0] gnt_next;
    logic [1:0] winner;
    logic       found;
    logic       release_now;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt, cnt_next;
    logic             timeout_hit;

    // A timeout only matters when somebody other than the owner is waiting.
    always_comb begin
        timeout_hit = (cnt == CNT_MAX) && (|(req & ~gnt));
    end

    // Hold counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end
`endif

    // Round-robin search starts one past the last owner and wraps around.
    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            logic [1:0] idx;
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Owner release, optionally forced by the hold timeout.
    always_comb begin
`ifdef ARB_TIMEOUT_EN
        release_now = !req[sel] || timeout_hit;
`else
        release_now = !req[sel];
`endif
    end

    // Next-state logic for state, grant, select, last owner and hold counter.
    always_comb begin
        state_next = state;
        gnt_next   = gnt;
        sel_next   = sel;
        last_next  = last;
`ifdef ARB_TIMEOUT_EN
        cnt_next   = cnt;
`endif
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_next = OWN;
                    gnt_next   = 4'b0001 << winner;
                    sel_next   = winner;
                    last_next  = winner;
`ifdef ARB_TIMEOUT_EN
                    cnt_next   = '0;
`endif
                end
            end
            OWN: begin
                if (release_now) begin
                    state_next = IDLE;
                    gnt_next   = '0;
                end else begin
`ifdef ARB_TIMEOUT_EN
                    if (cnt != CNT_MAX) begin
                        cnt_next = cnt + 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    // State and registered outputs; reset makes requester 0 the first winner.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= 2'd0;
            last  <= 2'd3;
        end else begin
            state <= state_next;
            gnt   <= gnt_next;
            sel   <= sel_next;
            last  <= last_next;
        end
    end

    // Busy flag follows the registered state.
    always_comb begin
        busy = (state == OWN);
    end

    // Data mux; the output is zero whenever there is no grant.
    always_comb begin
        out = '0;
        if (|gnt) begin
            unique case (sel)
                2'd0: out = in0;
                2'd1: out = in1;
                2'd2: out = in2;
                2'd3: out = in3;
                default: out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_arbiter.sv
// tb_mux4_arbiter: vector table plus scoreboard queue for mux4_arbiter.
// When built with ARB_TIMEOUT_EN, the bench also covers the timeout sequences.
module tb_mux4_arbiter;

    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        req;
    logic [DATA_W-1:0] in0, in1, in2, in3;
    logic [3:0]        gnt;
    logic [1:0]        sel;
    logic [DATA_W-1:0] out;
    logic              busy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
    } vec_t;

    typedef struct {
        logic [3:0]        gnt;
        logic [1:0]        sel;
        logic              busy;
        logic [DATA_W-1:0] out;
        int                tag;
    } exp_t;

    exp_t sb[$];

    mux4_arbiter #(
        .DATA_W (DATA_W),
        .TIMEOUT(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .in0  (in0),
        .in1  (in1),
        .in2  (in2),
        .in3  (in3),
        .gnt  (gnt),
        .sel  (sel),
        .out  (out),
        .busy (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] data_of(input logic [3:0] g, input logic [1:0] s);
        if (g == 4'b0000) return '0;
        case (s)
            2'd0: return 32'hA5A5_0000;
            2'd1: return 32'h1111_1111;
            2'd2: return 32'h2222_2222;
            default: return 32'h3333_3333;
        endcase
    endfunction

    task automatic check(input string name, input int tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, tag, act, exp);
        end
    endtask

    // Drive one cycle: push the expectation, clock, then pop and compare.
    task automatic step(input logic r, input logic [3:0] q, input exp_t e);
        exp_t got;
        reset = r;
        req   = q;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty step %0d", e.tag);
        end else begin
            got = sb.pop_front();
            check("gnt",  got.tag, DATA_W'(gnt),  DATA_W'(got.gnt));
            check("sel",  got.tag, DATA_W'(sel),  DATA_W'(got.sel));
            check("busy", got.tag, DATA_W'(busy), DATA_W'(got.busy));
            check("out",  got.tag, out,           got.out);
            check("onehot", got.tag, DATA_W'($countones(gnt) <= 1), DATA_W'(1));
        end
    endtask

    function automatic exp_t mk(input logic [3:0] g, input logic [1:0] s, input logic b, input int tag);
        exp_t e;
        e.gnt  = g;
        e.sel  = s;
        e.busy = b;
        e.out  = data_of(g, s);
        e.tag  = tag;
        return e;
    endfunction

    vec_t vecs[38];

    initial begin
        vecs = '{
            // reset, then single request from 0
            '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0},
            '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1},
            '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1},
            '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0},
            // all requesting, each owner drops after two cycles: 0,1,2,3,0
            '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0},
            '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1},
            '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1},
            '{1'b0, 4'b1110, 4'b0000, 2'd0, 1'b0},
            '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1},
            '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1},
            '{1'b0, 4'b1101, 4'b0000, 2'd1, 1'b0},
            '{1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1},
            '{1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1},
            '{1'b0, 4'b1011, 4'b0000, 2'd2, 1'b0},
            '{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1},
            '{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1},
            '{1'b0, 4'b0111, 4'b0000, 2'd3, 1'b0},
            '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1},
            '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1},
            '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0},
            // owner 2 holds while req[0] toggles
            '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1},
            '{1'b0, 4'b0101, 4'b0100, 2'd2, 1'b1},
            '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1},
            '{1'b0, 4'b0101, 4'b0100, 2'd2, 1'b1},
            '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1},
            '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0},
            // reset during ownership of 3, then 3 requests again
            '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1},
            '{1'b1, 4'b1000, 4'b0000, 2'd0, 1'b0},
            '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1},
            '{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0},
            // one-edge request gets a one-cycle grant
            '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1},
            '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0},
            // round-robin wrap and skip of idle requesters
            '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1},
            '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0},
            '{1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1},
            '{1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0},
            '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1},
            '{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0}
        };

        in0   = 32'hA5A5_0000;
        in1   = 32'h1111_1111;
        in2   = 32'h2222_2222;
        in3   = 32'h3333_3333;
        reset = 1'b1;
        req   = 4'b0000;
        @(posedge clk);
        #1;

        for (int i = 0; i < 38; i++) begin
            step(vecs[i].rst, vecs[i].req, mk(vecs[i].gnt, vecs[i].sel, vecs[i].busy, i));
        end

`ifdef ARB_TIMEOUT_EN
        // Two requesters held: 4 cycles each with one IDLE cycle between owners.
        step(1'b1, 4'b0000, mk(4'b0000, 2'd0, 1'b0, 100));
        for (int k = 1; k <= 20; k++) begin
            int m;
            m = (k - 1) % 10;
            if (m < 4)       step(1'b0, 4'b0011, mk(4'b0001, 2'd0, 1'b1, 100 + k));
            else if (m == 4) step(1'b0, 4'b0011, mk(4'b0000, 2'd0, 1'b0, 100 + k));
            else if (m < 9)  step(1'b0, 4'b0011, mk(4'b0010, 2'd1, 1'b1, 100 + k));
            else             step(1'b0, 4'b0011, mk(4'b0000, 2'd1, 1'b0, 100 + k));
        end
        // Lone requester: counter saturates, no forced release.
        step(1'b1, 4'b0000, mk(4'b0000, 2'd0, 1'b0, 200));
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 4'b0010, mk(4'b0010, 2'd1, 1'b1, 200 + k));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux4_arbiter.md
MUX4_ARBITER -- requirements
Module: mux4_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: width of each data input and of the output.
REQ-002 Parameter TIMEOUT, default 16: maximum ownership cycles; used only when ARB_TIMEOUT_EN is defined.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  4  level request; bit i is requester i.
REQ-006 in0, in1, in2, in3  input  DATA_W each  requester data sources.
REQ-007 gnt  output  4  registered one-hot grant; all zeros when no owner.
REQ-008 sel  output  2  registered mux select; equals the owner index.
REQ-009 out  output  DATA_W  selected data: in[sel] when gnt is nonzero, else zero; combinational from sel/gnt/in.
REQ-010 busy  output  1  high while in state OWN.

Function
REQ-011 The FSM SHALL have two states: IDLE (gnt=0) and OWN (exactly one gnt bit set).
REQ-012 In IDLE with req nonzero at an edge, the FSM SHALL enter OWN and set gnt/sel to the winner on that edge (1-cycle request-to-grant latency).
REQ-013 Winner selection SHALL be round-robin: search starts at (last+1) mod 4 and wraps; last is the most recent owner.
REQ-014 last SHALL update to the winner index on each IDLE->OWN transition.
REQ-015 In IDLE with req=0, the FSM SHALL stay in IDLE with gnt=0 and sel unchanged.
REQ-016 In OWN, while req[sel]=1 and no timeout fires, the FSM SHALL hold gnt/sel unchanged regardless of other req bits.
REQ-017 In OWN with req[sel]=0 at an edge, the FSM SHALL go to IDLE and clear gnt (one dead cycle before any new grant).
REQ-018 A request high for one edge only SHALL receive a one-cycle grant that is released on the following edge.
REQ-019 Changes on req bits other than the owner's SHALL NOT affect gnt during OWN, except through timeout.
REQ-020 gnt SHALL never have more than one bit set.
REQ-021 sel SHALL never change while busy=1.

Reset
REQ-022 reset=1 at an edge SHALL force IDLE, gnt=0, sel=0, busy=0, last=3 (requester 0 wins first), hold counter=0.
REQ-023 reset SHALL take priority over every other event, including mid-ownership; no grant survives reset.
REQ-024 out SHALL read zero in the cycle after reset.

Configuration
REQ-025 Macro ARB_TIMEOUT_EN SHALL compile in a hold counter that resets to 0 on entry to OWN and increments on each cycle in OWN.
REQ-026 With ARB_TIMEOUT_EN, when the counter equals TIMEOUT-1 and any other req bit is high, the FSM SHALL go to IDLE on that edge; the next grant then goes to a different requester.
REQ-027 With ARB_TIMEOUT_EN, if no other requester is pending at TIMEOUT-1, the counter SHALL saturate and ownership SHALL continue.
REQ-028 With ARB_TIMEOUT_EN, when owner release and timeout coincide on the same edge, the result SHALL be a normal release to IDLE.
REQ-029 Without ARB_TIMEOUT_EN, no counter SHALL exist and ownership SHALL last until req[sel] falls.

Verification
REQ-030 Reset, then req=0001 at edge 1 -> gnt=0001, sel=00, busy=1 after edge 1; out=in0 (e.g. 32'hA5A5_0000).
REQ-031 req=1111 held, each owner drops req for one edge after 2 cycles of ownership -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
REQ-032 Owner 2 holding, req[0] toggles every cycle -> gnt stays 0100 and sel stays 10 throughout.
REQ-033 Assert reset while gnt=1000 -> next cycle gnt=0000, sel=00, out=0; then req=1000 -> requester 3 is granted, since last=3 after reset and requester 0 has first priority only when requesting.
REQ-034 With ARB_TIMEOUT_EN, TIMEOUT=4, req=0011 held -> owner 0 holds 4 cycles, 1 IDLE cycle, owner 1 holds 4 cycles, and the pattern repeats.
REQ-035 With ARB_TIMEOUT_EN, only req[1] held for 20 cycles -> gnt=0010 continuously with no forced release.
